// File: rtl/tx_symbol_scheduler_pkg.sv
// Shared symbol codes, FSM/source enums and the registered symbol payload
// used by the transmit symbol scheduler.
package tx_symbol_scheduler_pkg;

  localparam int unsigned DK_W   = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OS_W   = 4;

  localparam logic [DK_W-1:0] DK_DATA = 4'b0000;
  localparam logic [DK_W-1:0] DK_COM  = 4'b0001;
  localparam logic [DK_W-1:0] DK_SKP  = 4'b0010;
  localparam logic [DK_W-1:0] DK_STP  = 4'b0011;
  localparam logic [DK_W-1:0] DK_SDP  = 4'b0100;
  localparam logic [DK_W-1:0] DK_END  = 4'b0101;
  localparam logic [DK_W-1:0] DK_EDB  = 4'b0110;
  localparam logic [DK_W-1:0] DK_FTS  = 4'b0111;
  localparam logic [DK_W-1:0] DK_IDLE = 4'b1000;

  // Ordered set is 4 COM followed by 12 SKP, always starting on lane 0
  localparam int unsigned OS_COM_CNT = 4;
  localparam int unsigned OS_SKP_CNT = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OS_COM,
    ST_OS_SKP,
    ST_HDR,
    ST_DATA,
    ST_TAIL,
    ST_DROP
  } state_e;

  typedef enum logic {
    SRC_TLP  = 1'b0,
    SRC_DLLP = 1'b1
  } src_e;

  typedef struct packed {
    logic [DK_W-1:0]   dk;
    logic [BYTE_W-1:0] data;
  } tx_sym_t;

endpackage

// File: rtl/tx_symbol_scheduler_skp_timer.sv
// SKP interval timer: counts enb cycles, raises a pending request at each wrap
// and flags a wrap that lands while the previous request is still unserved.
module skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic clear,
  output logic skp_pending,
  output logic missed_c
);

  localparam int unsigned CNT_W = $clog2(SKP_INTERVAL);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c   = enb && (cnt == CNT_W'(SKP_INTERVAL - 1));
  // A wrap coinciding with the clear starts a fresh request, so it is not a miss
  assign missed_c = wrap_c && skp_pending && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      skp_pending <= 1'b0;
    end else if (enb) begin
      cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      if (wrap_c) begin
        skp_pending <= 1'b1;
      end else if (clear) begin
        skp_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler: arbitrates TLP/DLLP sources, frames packets,
// pads with IDLE and inserts lane-aligned SKP ordered sets, one symbol per enb.
module tx_symbol_scheduler
  import tx_symbol_scheduler_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned MAX_LEN      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              tlp_valid,
  input  logic [BYTE_W-1:0] tlp_data,
  input  logic              tlp_last,
  input  logic              tlp_bad,
  output logic              tlp_ready,
  input  logic              dllp_valid,
  input  logic [BYTE_W-1:0] dllp_data,
  input  logic              dllp_last,
  output logic              dllp_ready,
  output logic [DK_W-1:0]   control_dk,
  output logic [BYTE_W-1:0] tx_DataE,
  output logic              skp_active,
  output logic              tx_err
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e            state, state_d;
  src_e              src, src_d;
  src_e              last_winner, last_winner_d;
  logic [LEN_W-1:0]  len_cnt, len_d;
  logic [OS_W-1:0]   os_cnt, os_d;
  logic [1:0]        lane_ptr;
  logic              bad_q, bad_d;
  tx_sym_t           sym_q, sym_d;
  logic              skp_active_d;
  logic              err_d;

  logic              skp_pending;
  logic              skp_missed_c;
  logic              skp_clear_c;

  logic              acc_valid_c;
  logic              acc_last_c;
  logic [BYTE_W-1:0] acc_data_c;
  logic              xfer_state_c;

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .clear      (skp_clear_c),
    .skp_pending(skp_pending),
    .missed_c   (skp_missed_c)
  );

  // Currently selected source, and the handshake it sees
  assign acc_valid_c  = (src == SRC_TLP) ? tlp_valid : dllp_valid;
  assign acc_last_c   = (src == SRC_TLP) ? tlp_last  : dllp_last;
  assign acc_data_c   = (src == SRC_TLP) ? tlp_data  : dllp_data;
  assign xfer_state_c = (state == ST_DATA) || (state == ST_DROP);

  assign tlp_ready  = enb && xfer_state_c && (src == SRC_TLP);
  assign dllp_ready = enb && xfer_state_c && (src == SRC_DLLP);

  assign control_dk = sym_q.dk;
  assign tx_DataE   = sym_q.data;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    src_d         = src;
    last_winner_d = last_winner;
    len_d         = len_cnt;
    os_d          = os_cnt;
    bad_d         = bad_q;
    sym_d.dk      = DK_IDLE;
    sym_d.data    = '0;
    skp_active_d  = 1'b0;
    err_d         = skp_missed_c;
    skp_clear_c   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (skp_pending) begin
          // Pending ordered set blocks new packets and waits for lane 0
          if (lane_ptr == 2'd0) begin
            sym_d.dk     = DK_COM;
            skp_active_d = 1'b1;
            skp_clear_c  = enb;
            os_d         = OS_W'(1);
            state_d      = ST_OS_COM;
          end
        end else if (dllp_valid && (!tlp_valid || last_winner == SRC_TLP)) begin
          sym_d.dk      = DK_SDP;
          src_d         = SRC_DLLP;
          last_winner_d = SRC_DLLP;
          len_d         = '0;
          bad_d         = 1'b0;
          state_d       = ST_DATA;
        end else if (tlp_valid) begin
          sym_d.dk      = DK_STP;
          src_d         = SRC_TLP;
          last_winner_d = SRC_TLP;
          len_d         = '0;
          bad_d         = 1'b0;
          state_d       = ST_DATA;
        end
      end

      ST_OS_COM: begin
        sym_d.dk     = DK_COM;
        skp_active_d = 1'b1;
        if (os_cnt == OS_W'(OS_COM_CNT - 1)) begin
          os_d    = '0;
          state_d = ST_OS_SKP;
        end else begin
          os_d = os_cnt + OS_W'(1);
        end
      end

      ST_OS_SKP: begin
        sym_d.dk     = DK_SKP;
        skp_active_d = 1'b1;
        if (os_cnt == OS_W'(OS_SKP_CNT - 1)) begin
          os_d    = '0;
          state_d = ST_IDLE;
        end else begin
          os_d = os_cnt + OS_W'(1);
        end
      end

      ST_DATA: begin
        if (!acc_valid_c) begin
          sym_d.dk = DK_EDB;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else if (len_cnt == LEN_W'(MAX_LEN)) begin
          // Byte beyond the length limit: abort, then swallow the rest
          sym_d.dk = DK_EDB;
          err_d    = 1'b1;
          state_d  = acc_last_c ? ST_IDLE : ST_DROP;
        end else begin
          sym_d.dk   = DK_DATA;
          sym_d.data = acc_data_c;
          len_d      = len_cnt + LEN_W'(1);
          if (acc_last_c) begin
            bad_d   = (src == SRC_TLP) && tlp_bad;
            state_d = ST_TAIL;
          end
        end
      end

      ST_TAIL: begin
        sym_d.dk = bad_q ? DK_EDB : DK_END;
        bad_d    = 1'b0;
        state_d  = ST_IDLE;
      end

      ST_DROP: begin
        if (acc_valid_c && acc_last_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; everything holds while enb is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      src         <= SRC_TLP;
      last_winner <= SRC_TLP;
      len_cnt     <= '0;
      os_cnt      <= '0;
      lane_ptr    <= '0;
      bad_q       <= 1'b0;
      sym_q.dk    <= DK_IDLE;
      sym_q.data  <= '0;
      skp_active  <= 1'b0;
      tx_err      <= 1'b0;
    end else if (enb) begin
      state       <= state_d;
      src         <= src_d;
      last_winner <= last_winner_d;
      len_cnt     <= len_d;
      os_cnt      <= os_d;
      lane_ptr    <= lane_ptr + 2'd1;
      bad_q       <= bad_d;
      sym_q       <= sym_d;
      skp_active  <= skp_active_d;
      tx_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed, table-driven bench for tx_symbol_scheduler with SKP_INTERVAL=32, MAX_LEN=8.
module tb_tx_symbol_scheduler;

  localparam logic [3:0] C_DATA = 4'h0;
  localparam logic [3:0] C_COM  = 4'h1;
  localparam logic [3:0] C_SKP  = 4'h2;
  localparam logic [3:0] C_STP  = 4'h3;
  localparam logic [3:0] C_SDP  = 4'h4;
  localparam logic [3:0] C_END  = 4'h5;
  localparam logic [3:0] C_EDB  = 4'h6;
  localparam logic [3:0] C_IDLE = 4'h8;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       tlp_valid, tlp_last, tlp_bad, tlp_ready;
  logic [7:0] tlp_data;
  logic       dllp_valid, dllp_last, dllp_ready;
  logic [7:0] dllp_data;
  logic [3:0] control_dk;
  logic [7:0] tx_DataE;
  logic       skp_active, tx_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       tv;
    logic [7:0] td;
    logic       tl;
    logic       tb;
    logic       dv;
    logic [7:0] dd;
    logic       dl;
    logic [3:0] dk;
    logic [7:0] dat;
    logic       tr;
    logic       dr;
    logic       skp;
    logic       err;
  } vec_t;

  vec_t vq[$];

  tx_symbol_scheduler #(
    .SKP_INTERVAL(32),
    .MAX_LEN     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .tlp_valid (tlp_valid),
    .tlp_data  (tlp_data),
    .tlp_last  (tlp_last),
    .tlp_bad   (tlp_bad),
    .tlp_ready (tlp_ready),
    .dllp_valid(dllp_valid),
    .dllp_data (dllp_data),
    .dllp_last (dllp_last),
    .dllp_ready(dllp_ready),
    .control_dk(control_dk),
    .tx_DataE  (tx_DataE),
    .skp_active(skp_active),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic v(input logic en, input logic tv, input logic [7:0] td,
                   input logic tl, input logic tb, input logic dv,
                   input logic [7:0] dd, input logic dl, input logic [3:0] dk,
                   input logic [7:0] dat, input logic tr, input logic dr,
                   input logic skp, input logic err);
    vec_t x;
    x.en = en; x.tv = tv; x.td = td; x.tl = tl; x.tb = tb;
    x.dv = dv; x.dd = dd; x.dl = dl;
    x.dk = dk; x.dat = dat; x.tr = tr; x.dr = dr; x.skp = skp; x.err = err;
    vq.push_back(x);
  endtask

  // TLP-only cycle with enb high
  task automatic t(input logic tv, input logic [7:0] td, input logic tl, input logic tb,
                   input logic [3:0] dk, input logic [7:0] dat, input logic tr, input logic err);
    v(1'b1, tv, td, tl, tb, 1'b0, 8'h00, 1'b0, dk, dat, tr, 1'b0, 1'b0, err);
  endtask

  task automatic idle_v(input int n);
    for (int i = 0; i < n; i++) t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int step, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got dk=%h data=%h tr=%b dr=%b skp=%b err=%b, required dk=%h data=%h tr=%b dr=%b skp=%b err=%b",
               name, step, got[15:12], got[11:4], got[3], got[2], got[1], got[0],
               exp[15:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [15:0] outs();
    return {control_dk, tx_DataE, tlp_ready, dllp_ready, skp_active, tx_err};
  endfunction

  // Reset, check reset state, then play the queued vectors one enb edge each
  task automatic run(input string name);
    rst = 1'b0; enb = 1'b0;
    tlp_valid = 1'b0; tlp_data = 8'h00; tlp_last = 1'b0; tlp_bad = 1'b0;
    dllp_valid = 1'b0; dllp_data = 8'h00; dllp_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({name, "_reset"}, 0, outs(), {C_IDLE, 8'h00, 4'b0000});
    rst = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      enb = vq[i].en;
      tlp_valid = vq[i].tv; tlp_data = vq[i].td; tlp_last = vq[i].tl; tlp_bad = vq[i].tb;
      dllp_valid = vq[i].dv; dllp_data = vq[i].dd; dllp_last = vq[i].dl;
      @(posedge clk);
      #1;
      check(name, i + 1, outs(),
            {vq[i].dk, vq[i].dat, vq[i].tr, vq[i].dr, vq[i].skp, vq[i].err});
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b0; enb = 1'b0;
    tlp_valid = 1'b0; tlp_data = 8'h00; tlp_last = 1'b0; tlp_bad = 1'b0;
    dllp_valid = 1'b0; dllp_data = 8'h00; dllp_last = 1'b0;

    idle_v(6);
    run("idle");

    t(1'b1, 8'hA1, 1'b0, 1'b0, C_STP,  8'h00, 1'b1, 1'b0);
    t(1'b1, 8'hA1, 1'b0, 1'b0, C_DATA, 8'hA1, 1'b1, 1'b0);
    t(1'b1, 8'hA2, 1'b0, 1'b0, C_DATA, 8'hA2, 1'b1, 1'b0);
    t(1'b1, 8'hA3, 1'b1, 1'b0, C_DATA, 8'hA3, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_END,  8'h00, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    run("tlp3");

    v(1, 1, 8'hB1, 1, 0, 1, 8'hD1, 1, C_SDP,  8'h00, 0, 1, 0, 0);
    v(1, 1, 8'hB1, 1, 0, 1, 8'hD1, 1, C_DATA, 8'hD1, 0, 0, 0, 0);
    v(1, 1, 8'hB1, 1, 0, 1, 8'hD2, 1, C_END,  8'h00, 0, 0, 0, 0);
    v(1, 1, 8'hB1, 1, 0, 1, 8'hD2, 1, C_STP,  8'h00, 1, 0, 0, 0);
    v(1, 1, 8'hB1, 1, 0, 1, 8'hD2, 1, C_DATA, 8'hB1, 0, 0, 0, 0);
    v(1, 1, 8'hB2, 1, 0, 1, 8'hD2, 1, C_END,  8'h00, 0, 0, 0, 0);
    v(1, 1, 8'hB2, 1, 0, 1, 8'hD2, 1, C_SDP,  8'h00, 0, 1, 0, 0);
    v(1, 1, 8'hB2, 1, 0, 1, 8'hD2, 1, C_DATA, 8'hD2, 0, 0, 0, 0);
    v(1, 1, 8'hB2, 1, 0, 0, 8'h00, 0, C_END,  8'h00, 0, 0, 0, 0);
    v(1, 1, 8'hB2, 1, 0, 0, 8'h00, 0, C_STP,  8'h00, 1, 0, 0, 0);
    v(1, 1, 8'hB2, 1, 0, 0, 8'h00, 0, C_DATA, 8'hB2, 0, 0, 0, 0);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, C_END,  8'h00, 0, 0, 0, 0);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, C_IDLE, 8'h00, 0, 0, 0, 0);
    run("arb");

    t(1'b1, 8'hC1, 1'b0, 1'b0, C_STP, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++)
      t(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, C_DATA, 8'(8'hC0 + i), 1'b1, 1'b0);
    t(1'b1, 8'hC9, 1'b0, 1'b0, C_EDB,  8'h00, 1'b1, 1'b1);
    t(1'b1, 8'hCA, 1'b1, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    run("oversize");

    t(1'b1, 8'hE1, 1'b0, 1'b0, C_STP,  8'h00, 1'b1, 1'b0);
    t(1'b1, 8'hE1, 1'b0, 1'b0, C_DATA, 8'hE1, 1'b1, 1'b0);
    t(1'b1, 8'hE2, 1'b0, 1'b0, C_DATA, 8'hE2, 1'b1, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_EDB,  8'h00, 1'b0, 1'b1);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    run("underrun");

    t(1'b1, 8'hF1, 1'b0, 1'b0, C_STP,  8'h00, 1'b1, 1'b0);
    t(1'b1, 8'hF1, 1'b0, 1'b0, C_DATA, 8'hF1, 1'b1, 1'b0);
    t(1'b1, 8'hF2, 1'b1, 1'b1, C_DATA, 8'hF2, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_EDB,  8'h00, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    run("tlp_bad");

    t(1'b1, 8'h91, 1'b0, 1'b0, C_STP,  8'h00, 1'b1, 1'b0);
    t(1'b1, 8'h91, 1'b0, 1'b0, C_DATA, 8'h91, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      v(0, 1, 8'h92, 0, 0, 0, 8'h00, 0, C_DATA, 8'h91, 0, 0, 0, 0);
    t(1'b1, 8'h92, 1'b0, 1'b0, C_DATA, 8'h92, 1'b1, 1'b0);
    t(1'b1, 8'h93, 1'b1, 1'b0, C_DATA, 8'h93, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_END,  8'h00, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    run("enb_hold");

    // Timer wraps on edge 32 inside a 7-byte TLP; pad lanes 2,3 then ordered set
    idle_v(25);
    t(1'b1, 8'h51, 1'b0, 1'b0, C_STP, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++)
      t(1'b1, 8'(8'h50 + i), (i == 7), 1'b0, C_DATA, 8'(8'h50 + i), (i != 7), 1'b0);
    t(1'b1, 8'h77, 1'b1, 1'b0, C_END,  8'h00, 1'b0, 1'b0);
    t(1'b1, 8'h77, 1'b1, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    t(1'b1, 8'h77, 1'b1, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      v(1, 1, 8'h77, 1, 0, 0, 8'h00, 0, C_COM, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 12; i++)
      v(1, 1, 8'h77, 1, 0, 0, 8'h00, 0, C_SKP, 8'h00, 0, 0, 1, 0);
    t(1'b1, 8'h77, 1'b1, 1'b0, C_STP,  8'h00, 1'b1, 1'b0);
    t(1'b1, 8'h77, 1'b1, 1'b0, C_DATA, 8'h77, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_END,  8'h00, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    run("skp_os");

    // Endless oversize packet holds DROP past two wraps: second wrap is a miss
    t(1'b1, 8'h61, 1'b0, 1'b0, C_STP, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++)
      t(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, C_DATA, 8'(8'h60 + i), 1'b1, 1'b0);
    t(1'b1, 8'h69, 1'b0, 1'b0, C_EDB, 8'h00, 1'b1, 1'b1);
    for (int e = 11; e <= 70; e++)
      t(1'b1, 8'h69, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b1, (e == 64));
    t(1'b1, 8'h6A, 1'b1, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    t(1'b0, 8'h00, 1'b0, 1'b0, C_IDLE, 8'h00, 1'b0, 1'b0);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, C_COM, 8'h00, 0, 0, 1, 0);
    v(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, C_COM, 8'h00, 0, 0, 1, 0);
    run("skp_missed");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
